// File: rtl/parc_inst_fetch_queue_pkg.sv
// Shared PARC instruction-message fields and fetch-queue predecode bit positions.
// Used by parc_inst_fetch_queue (optional PARC_IFQ_BYPASS_EN) and parc_inst_predecode.
package parc_inst_fetch_queue_pkg;

  localparam int PARC_INST_MSG_SZ     = 32;

  localparam int PARC_IFQ_PDEC_BRANCH = 0;
  localparam int PARC_IFQ_PDEC_JUMP   = 1;
  localparam int PARC_IFQ_PDEC_MEM    = 2;
  localparam int PARC_IFQ_PDEC_MULDIV = 3;
  localparam int PARC_IFQ_PDEC_SZ     = 4;

  typedef logic [5:0] parc_field_t;

  function automatic parc_field_t parc_inst_msg_opcode(input logic [PARC_INST_MSG_SZ-1:0] inst);
    return inst[31:26];
  endfunction

  function automatic parc_field_t parc_inst_msg_func(input logic [PARC_INST_MSG_SZ-1:0] inst);
    return inst[5:0];
  endfunction

endpackage

// File: rtl/parc_inst_fetch_queue_predecode.sv
// Combinational predecode of a PARC instruction into control-class bits
// {is_muldiv, is_mem, is_jump, is_branch}.
module parc_inst_predecode
  import parc_inst_fetch_queue_pkg::*;
(
  input  logic [PARC_INST_MSG_SZ-1:0] inst,
  output logic [PARC_IFQ_PDEC_SZ-1:0] pdec
);

  parc_field_t opcode_s;
  parc_field_t func_s;

  assign opcode_s = parc_inst_msg_opcode(inst);
  assign func_s   = parc_inst_msg_func(inst);

  // Classify by opcode; SPECIAL (opcode 0) only matters for JR/JALR.
  always_comb begin
    pdec = {PARC_IFQ_PDEC_SZ{1'b0}};
    case (opcode_s)
      6'b000001, 6'b000100, 6'b000101,
      6'b000110, 6'b000111: pdec[PARC_IFQ_PDEC_BRANCH] = 1'b1;
      6'b000010, 6'b000011: pdec[PARC_IFQ_PDEC_JUMP]   = 1'b1;
      6'b000000: begin
        if ((func_s == 6'b001000) || (func_s == 6'b001001)) begin
          pdec[PARC_IFQ_PDEC_JUMP] = 1'b1;
        end else begin
          pdec[PARC_IFQ_PDEC_JUMP] = 1'b0;
        end
      end
      6'b011100: pdec[PARC_IFQ_PDEC_MULDIV] = 1'b1;
      default: begin
        if (opcode_s[5:4] == 2'b10) begin
          pdec[PARC_IFQ_PDEC_MEM] = 1'b1;
        end else begin
          pdec[PARC_IFQ_PDEC_MEM] = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/parc_inst_fetch_queue.sv
// Instruction fetch queue between imem and decode, predecoding on enqueue.
// Define PARC_IFQ_BYPASS_EN to let an empty queue pass enq straight to deq.
module parc_inst_fetch_queue
  import parc_inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          enq_val,
  output logic                          enq_rdy,
  input  logic [31:0]                   enq_pc,
  input  logic [PARC_INST_MSG_SZ-1:0]   enq_inst,
  output logic                          deq_val,
  input  logic                          deq_rdy,
  output logic [31:0]                   deq_pc,
  output logic [PARC_INST_MSG_SZ-1:0]   deq_inst,
  output logic [PARC_IFQ_PDEC_SZ-1:0]   deq_pdec,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]                 ent_pc_q   [DEPTH];
  logic [PARC_INST_MSG_SZ-1:0] ent_inst_q [DEPTH];
  logic [PARC_IFQ_PDEC_SZ-1:0] ent_pdec_q [DEPTH];

  logic [PARC_IFQ_PDEC_SZ-1:0] enq_pdec_s;
  logic empty_s, full_s, byp_s;
  logic enq_fire_s, deq_fire_s, wr_s, pop_s;

  parc_inst_predecode u_predecode (
    .inst (enq_inst),
    .pdec (enq_pdec_s)
  );

  assign empty_s = (count_q == {CW{1'b0}});
  assign full_s  = (count_q == CW'(DEPTH));

`ifdef PARC_IFQ_BYPASS_EN
  assign byp_s = empty_s;
`else
  assign byp_s = 1'b0;
`endif

  // Handshakes and head-of-queue presentation; bypass path shares the enq predecoder.
  always_comb begin
    enq_rdy = reset && !flush && !full_s;
    if (byp_s) begin
      deq_val  = reset && !flush && enq_val;
      deq_pc   = enq_pc;
      deq_inst = enq_inst;
      deq_pdec = enq_pdec_s;
    end else begin
      deq_val  = reset && !flush && !empty_s;
      deq_pc   = ent_pc_q[head_q];
      deq_inst = ent_inst_q[head_q];
      deq_pdec = ent_pdec_q[head_q];
    end
    enq_fire_s = enq_val && enq_rdy;
    deq_fire_s = deq_val && deq_rdy;
    // A bypassed instruction consumed the same cycle is never stored.
    wr_s  = enq_fire_s && !(byp_s && deq_rdy);
    pop_s = deq_fire_s && !byp_s;
  end

  // Pointer and occupancy next-state; flush wipes the queue in one cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (wr_s) begin
        tail_d = tail_q + AW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + AW'(1);
      end else begin
        head_d = head_q;
      end
      case ({wr_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      ent_pc_q[tail_q]   <= enq_pc;
      ent_inst_q[tail_q] <= enq_inst;
      ent_pdec_q[tail_q] <= enq_pdec_s;
    end
  end

  assign count = reset ? count_q : {CW{1'b0}};

endmodule

// File: tb/tb_parc_inst_fetch_queue.sv
// Scoreboard bench for parc_inst_fetch_queue: directed scenarios then random traffic,
// checked against a queue-based reference model (honours PARC_IFQ_BYPASS_EN).
module tb_parc_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        enq_val;
  logic        enq_rdy;
  logic [31:0] enq_pc;
  logic [31:0] enq_inst;
  logic        deq_val;
  logic        deq_rdy;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic [3:0]  deq_pdec;
  logic [2:0]  count;

  parc_inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .enq_val  (enq_val),
    .enq_rdy  (enq_rdy),
    .enq_pc   (enq_pc),
    .enq_inst (enq_inst),
    .deq_val  (deq_val),
    .deq_rdy  (deq_rdy),
    .deq_pc   (deq_pc),
    .deq_inst (deq_inst),
    .deq_pdec (deq_pdec),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t sb[$];
  int n_total = 0;
  int n_pass  = 0;

  // Reference predecode straight from the opcode/func classification rules.
  function automatic logic [3:0] ref_pdec(input logic [31:0] i);
    logic [5:0] op;
    logic [5:0] fn;
    logic br, jp, mm, md;
    op = i[31:26];
    fn = i[5:0];
    br = op inside {6'o04, 6'o05, 6'o06, 6'o07, 6'o01};
    jp = (op inside {6'o02, 6'o03}) || (op == 6'o00 && (fn inside {6'o10, 6'o11}));
    mm = (op >= 6'd32) && (op <= 6'd47);
    md = (op == 6'd28);
    return {md, mm, jp, br};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: check flow-control/count each cycle, pop and compare on dequeue, push on enqueue.
  always @(negedge clk) begin
    logic   byp, exp_rdy, exp_val;
    entry_t e;
    byp = 1'b0;
`ifdef PARC_IFQ_BYPASS_EN
    byp = (sb.size() == 0);
`endif
    exp_rdy = reset && !flush && (sb.size() != DEPTH);
    exp_val = reset && !flush && (byp ? enq_val : (sb.size() != 0));
    chk("enq_rdy", {31'd0, enq_rdy}, {31'd0, exp_rdy});
    chk("deq_val", {31'd0, deq_val}, {31'd0, exp_val});
    chk("count", {29'd0, count}, reset ? 32'(sb.size()) : 32'd0);
    if (exp_val && deq_rdy) begin
      if (byp) begin
        e.pc   = enq_pc;
        e.inst = enq_inst;
      end else begin
        e = sb.pop_front();
      end
      chk("deq_pc", deq_pc, e.pc);
      chk("deq_inst", deq_inst, e.inst);
      chk("deq_pdec", {28'd0, deq_pdec}, {28'd0, ref_pdec(e.inst)});
    end
    if (enq_val && exp_rdy && !(byp && deq_rdy)) begin
      e.pc   = enq_pc;
      e.inst = enq_inst;
      sb.push_back(e);
    end
    if (!reset || flush) begin
      sb.delete();
    end
  end

  task automatic cyc(input logic ev, input logic [31:0] pc, input logic [31:0] inst,
                     input logic dr, input logic fl, input logic rs);
    enq_val  = ev;
    enq_pc   = pc;
    enq_inst = inst;
    deq_rdy  = dr;
    flush    = fl;
    reset    = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [5:0]  ops [8];
    ops[0] = 6'o00; ops[1] = 6'o01; ops[2] = 6'o02; ops[3] = 6'o04;
    ops[4] = 6'd28; ops[5] = 6'd35; ops[6] = 6'd43; ops[7] = 6'o03;
    r = $urandom;
    if ($urandom_range(0, 1) == 0) begin
      r[31:26] = ops[$urandom_range(0, 7)];
    end
    if ($urandom_range(0, 2) == 0) begin
      r[5:0] = ($urandom_range(0, 1) == 0) ? 6'o10 : 6'o11;
    end
    return r;
  endfunction

  localparam logic [31:0] ADDU = 32'h00430821;
  localparam logic [31:0] LH   = 32'h84ac0004;
  localparam logic [31:0] JMP  = 32'h08000010;
  localparam logic [31:0] BNE  = 32'h15540004;
  localparam logic [31:0] MUL  = 32'h73cc0802;
  localparam logic [31:0] JR   = 32'h03e00008;

  initial begin
    logic [31:0] tbl [6];
    logic [31:0] pc;
    tbl[0] = ADDU; tbl[1] = LH; tbl[2] = JMP; tbl[3] = BNE; tbl[4] = MUL; tbl[5] = JR;

    // Reset, with enqueue attempts that must be refused.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0, ADDU, 1'b1, 1'b0, 1'b0);

    // Three instructions streamed to an always-ready decode.
    cyc(1'b1, 32'h1000, ADDU, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h1004, LH,   1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h1008, JMP,  1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Fill past DEPTH with decode stalled, release one, then stream across wrap.
    pc = 32'h2000;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, pc, tbl[i], 1'b0, 1'b0, 1'b1);
      pc += 32'd4;
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, pc, BNE, 1'b0, 1'b0, 1'b1);
    pc += 32'd4;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, pc, tbl[i % 6], 1'b1, 1'b0, 1'b1);
      pc += 32'd4;
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Flush at count=3 while both sides try to fire.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h3000 + 32'(i * 4), tbl[i + 3], 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h300c, MUL, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Reset asserted with two entries held.
    cyc(1'b1, 32'h4000, BNE, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h4004, JR,  1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h4008, MUL, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h400c, MUL, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Empty queue, enqueue with decode ready: bypass or one-cycle latency.
    cyc(1'b1, 32'h5000, LH, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Random traffic with occasional flush and reset.
    pc = 32'h8000;
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, pc, rand_inst(), $urandom_range(0, 2) != 0,
          $urandom_range(0, 31) == 0, $urandom_range(0, 63) != 0);
      pc += 32'd4;
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/parc_inst_fetch_queue.md
# parc_inst_fetch_queue

Instruction fetch queue for the pv2ooo core: buffers instruction-memory responses (PC plus 32-bit PARC instruction message) between fetch and decode. Each entry is predecoded on enqueue into control-class bits that the decode/rename logic consumes directly. Flushed in one cycle on a branch or jump redirect. Val/rdy handshakes on both sides decouple imem latency from decode stalls.

## Interface
- `DEPTH`, default 4, number of entries; must be a power of two, ≥2
- `clk` in 1, rising-edge clock
- `reset` in 1, synchronous, active-low (0 = reset)
- `flush` in 1, redirect squash; clears all entries
- `enq_val` in 1, incoming instruction valid
- `enq_rdy` out 1, queue can accept
- `enq_pc` in 32, PC of incoming instruction
- `enq_inst` in `PARC_INST_MSG_SZ` (32), instruction message
- `deq_val` out 1, head entry valid
- `deq_rdy` in 1, decode accepts head
- `deq_pc` out 32, head PC
- `deq_inst` out 32, head instruction
- `deq_pdec` out 4, head predecode {is_muldiv, is_mem, is_jump, is_branch}
- `count` out clog2(DEPTH+1), occupied entries

## Operation
- Storage: circular buffer of DEPTH entries {pc, inst, pdec}; head ptr, tail ptr (clog2(DEPTH) bits, wrap naturally), count register.
- Enqueue fires on `enq_val && enq_rdy`: write entry at tail, tail+1.
- Dequeue fires on `deq_val && deq_rdy`: head+1.
- `enq_rdy = reset && !flush && (count != DEPTH)`. Full queue never accepts, even if a dequeue fires that cycle.
- `deq_val = reset && !flush && (count != 0)`. `deq_*` data is driven from the head entry combinationally.
- Count: +1 on enq only, −1 on deq only, unchanged on both.
- Predecode is computed from `enq_inst` at enqueue:
  - is_branch: opcode 000100/000101/000110/000111/000001.
  - is_jump: opcode 000010/000011, or opcode 000000 with func 001000/001001.
  - is_mem: opcode 100xxx or 101xxx.
  - is_muldiv: opcode 011100.
  - Otherwise 0.
- Flush: at the next edge, count=0 and head=tail=0. Any enq/deq presented in the flush cycle is ignored, and no handshake fires because the rdy/val signals are forced low.
- Reset (reset==0 at the edge): same clear as flush. Mid-operation reset discards contents. While reset==0, `enq_rdy=0`, `deq_val=0`, `count=0`.
- Entry data contents are not reset; only pointers and count are.

## Timing
- Minimum enq→deq latency: 1 cycle (entry written at edge N, `deq_val` high in cycle N+1). Bypass mode below gives 0.
- Sustains 1 enq + 1 deq per cycle when 0 < count < DEPTH.
- Full (count==DEPTH): `enq_rdy=0`. After one dequeue, `enq_rdy=1` the next cycle.
- Empty: `deq_val=0` (non-bypass).
- Pointer wrap from DEPTH−1 to 0 is seamless; order is preserved across wrap.
- Flush takes precedence over reset-free enq/deq. Reset takes precedence over flush.

## Configuration
- `PARC_IFQ_BYPASS_EN` defined: when count==0 and !flush, `deq_val=enq_val` and `deq_*` are driven from `enq_*`, with predecode computed combinationally. If `deq_rdy` is high, the instruction passes through in 0 cycles and is not written. If `deq_rdy` is low, it is enqueued normally.
- `PARC_IFQ_BYPASS_EN` undefined: no enq→deq combinational path; minimum latency is 1 cycle.

## Structure
- Predecode bit positions (`PARC_IFQ_PDEC_BRANCH`=0, `_JUMP`=1, `_MEM`=2, `_MULDIV`=3) and `PARC_IFQ_PDEC_SZ`=4 go in the shared instruction-message defines file alongside the opcode/func field macros. Field extraction uses the existing `PARC_INST_MSG_OPCODE` and `PARC_INST_MSG_FUNC` macros.
- Sub-module `parc_inst_predecode`: combinational, takes inst and returns pdec. One instance sits on the enq path and is shared with the bypass path.

## Test plan
- Reset then 3 enq (pc 0x1000/0x1004/0x1008, ADDU/LH 0x84ac0004/J 0x08000010), deq_rdy=1 → deq order matches; pdec 0000, 0100, 0010; count returns to 0.
- Fill DEPTH=4 with deq_rdy=0 → `enq_rdy=0` at count=4. Then one deq → `enq_rdy=1` the next cycle. Enq+deq alternating 10 times across wrap → FIFO order preserved.
- count=3, flush with enq_val=1 and deq_rdy=1 → no fire; count=0 next cycle; `deq_val=0`.
- BNE 0x15540004 and MUL 0x73cc0802 enqueued → pdec 0001 and 1000. JR 0x03e00008 → pdec 0010.
- reset=0 asserted mid-stream at count=2 → `enq_rdy=0` and `deq_val=0` during reset; count=0 after release.
- With `PARC_IFQ_BYPASS_EN`, empty queue, enq_val=1, deq_rdy=1 → `deq_val=1` the same cycle with `deq_pc=enq_pc`; count stays 0. Without the macro → `deq_val` high one cycle later.
